// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: in-order imem requests, DEPTH-entry instruction/PC queue, redirect flush.
// Optional same-cycle response-to-decode bypass enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue_unit #(
  parameter int                XLEN    = 32,
  parameter int                DEPTH   = 4,
  parameter logic [XLEN-1:0]   INIT_PC = XLEN'(32'h0100_0000),
  parameter int                CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_insn,
  output logic [XLEN-1:0]  deq_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [31:0]      insn_q [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  rpc_q  [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rpc_rd, rpc_wr;
  logic [CNT_W-1:0] count_r, inflight;
  // One extra bit: back-to-back redirects can stack stale responses beyond DEPTH.
  logic [CNT_W:0]   drop;

  logic [CNT_W:0]   credits;
  logic             rsp_live, rsp_drop, byp_valid, q_push, q_pop;
  logic [XLEN-1:0]  head_pc;

  always_comb begin
    credits   = {1'b0, count_r} + {1'b0, inflight};
    imem_req  = reset_n && !redirect && (credits < (CNT_W + 1)'(DEPTH));
    imem_addr = fetch_pc;
    rsp_drop  = imem_rsp_valid && (drop != '0);
    rsp_live  = imem_rsp_valid && (drop == '0) && (inflight != '0);
    head_pc   = rpc_q[rpc_rd];
`ifdef FETCHQ_BYPASS_EN
    byp_valid = rsp_live && !redirect && (count_r == '0);
`else
    byp_valid = 1'b0;
`endif
    deq_valid = (count_r != '0) || byp_valid;
    deq_insn  = byp_valid ? imem_rsp_data : insn_q[rd_ptr];
    deq_pc    = byp_valid ? head_pc : pc_q[rd_ptr];
    q_pop     = !redirect && (count_r != '0) && deq_ready;
    q_push    = !redirect && rsp_live && !(byp_valid && deq_ready);
    count     = count_r;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= INIT_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rpc_rd   <= '0;
      rpc_wr   <= '0;
      count_r  <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Every request still in memory becomes a response to throw away.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rpc_rd   <= '0;
      rpc_wr   <= '0;
      count_r  <= '0;
      inflight <= '0;
      drop     <= drop + {1'b0, inflight}
                  - (CNT_W + 1)'(imem_rsp_valid && (drop != '0 || inflight != '0));
    end else begin
      if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        rpc_wr   <= rpc_wr + PW'(1);
      end
      if (rsp_live) rpc_rd <= rpc_rd + PW'(1);
      if (q_push)   wr_ptr <= wr_ptr + PW'(1);
      if (q_pop)    rd_ptr <= rd_ptr + PW'(1);
      if (rsp_drop) drop   <= drop - (CNT_W + 1)'(1);
      count_r  <= count_r + CNT_W'(q_push) - CNT_W'(q_pop);
      inflight <= inflight + CNT_W'(imem_req) - CNT_W'(rsp_live);
    end
  end

  always_ff @(posedge clock) begin
    if (q_push) begin
      insn_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]   <= head_pc;
    end
    if (imem_req) rpc_q[rpc_wr] <= fetch_pc;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the fixed pc_f register and its direct insn_d feed. It generates fetch addresses, issues in-order requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode pops from the queue with a valid/ready handshake; jump and branch logic redirects the unit via a flush.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, queue entries; power of two, >= 2
INIT_PC, 32'h0100_0000, PC fetched first after reset
CNT_W, $clog2(DEPTH+1), width of occupancy and in-flight counters

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request this cycle; memory always accepts
imem_addr  out  XLEN  fetch address (= fetch PC)
imem_rsp_valid  in  1  response valid; in order, >= 1 cycle after its request
imem_rsp_data  in  32  returned instruction word
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch PC
deq_valid  out  1  queue head valid
deq_ready  in  1  decode accepts head
deq_insn  out  32  head instruction
deq_pc  out  XLEN  head PC
count  out  CNT_W  current queue occupancy

Behaviour:
- Reset is asynchronous and active-low (reset_n = 0). While in reset: fetch PC = INIT_PC, queue empty, count = 0, inflight = 0, drop = 0, deq_valid = 0, imem_req = 0.
- State registers:
  - fetch PC.
  - Circular queue: rd/wr pointers plus count.
  - inflight: live requests whose responses are not yet returned.
  - drop: stale responses still to be discarded.
  - Request-PC FIFO of depth DEPTH that pairs each response with its PC.
- Request issue (combinational):
  - imem_req = !redirect && (count + inflight < DEPTH).
  - imem_addr = fetch PC.
  - On imem_req, fetch PC += 4 (mod 2^XLEN wrap) and the PC is pushed to the request-PC FIFO.
- Response handling:
  - If drop > 0: drop decrements, and the response is discarded.
  - Otherwise: {imem_rsp_data, popped request PC} is written at wr pointer, and inflight decrements.
  - Credit accounting guarantees the queue is never full on a live response.
- Dequeue:
  - deq_valid = (count != 0); deq_insn and deq_pc come from the rd-pointer entry.
  - The pop happens when deq_valid && deq_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (highest priority, single cycle):
  - Next cycle: queue empty, count = 0, pointers reset, request-PC FIFO cleared, fetch PC = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop <= drop + inflight − (1 if a response arrives this cycle, else 0); inflight <= 0.
  - No request is issued during the redirect cycle.
  - A dequeue handshake in the same cycle is discarded along with the flush; the consumer owns its own kill.
- Pointer wrap: rd and wr wrap at DEPTH; the full/empty distinction uses count.
- Latency (bypass off):
  - Request to response takes >= 1 cycle (memory dependent).
  - Response to deq_valid takes 1 cycle.
  - Steady state with deq_ready = 1 and 1-cycle memory: 1 instruction/cycle.
- A response while inflight = 0 and drop = 0 is illegal and is ignored.
- Reset asserted mid-operation clears all state immediately. The first request after release is INIT_PC.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined: when the queue is empty and a live response arrives, deq_valid/deq_insn/deq_pc are driven from the response in the same cycle.
  - If deq_ready = 1, the entry is not written and count stays 0.
  - If deq_ready = 0, the entry is enqueued normally.
  - Redirect still suppresses the bypass.
- Undefined: every response is registered in the queue first, so there is at least 1 cycle from response to deq_valid.

Test Plan:
- Reset release, 1-cycle memory returning data = addr, deq_ready = 1 -> first deq_pc 0x01000000 with deq_insn 0x01000000; then one pop/cycle at PCs 0x01000004, 0x01000008, ...
- deq_ready = 0 from reset -> exactly 4 requests issued (0x01000000..0x0100000C), count reaches 4, imem_req stays 0; raising deq_ready resumes in order at 0x01000010.
- 3-cycle memory, redirect to 0x01000040 with 2 requests in flight -> count = 0 next cycle, the next 2 responses discarded, next deq_pc 0x01000040.
- Redirect with redirect_pc 0x01000042 -> next imem_addr 0x01000040.
- count = 1 with a response and deq_ready both asserted in the same cycle -> count stays 1 and order is preserved; with FETCHQ_BYPASS_EN and count = 0, a response plus deq_ready -> deq_valid the same cycle and count stays 0.
- reset_n pulsed low mid-stream with entries queued -> deq_valid drops immediately, first request after release is 0x01000000, and no stale response is enqueued.
